wasm_loader_v2: RTL

// Boot-time WASM module walker, generalised successor of the single-function loader. Fetches the module

---
 rtl/wasm_loader_v2.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/wasm_loader_v2.sv
// Boot-time WASM module walker: magic check, LEB128 section walk,
// per-function table of body address and local count.
module wasm_loader_v2 #(
  parameter int unsigned ADDR_W = 32,
  parameter logic [ADDR_W-1:0] CODE_BASE = 'h30,
  parameter int unsigned PTR_BYTES = 1,
  parameter int unsigned MAX_FUNCS = 16,
  parameter int unsigned LOCALS_W = 8,
  localparam int unsigned FIDX_W = $clog2(MAX_FUNCS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] addr,
  output logic              memory_read_en,
  input  logic [7:0]        data_out,
  input  logic              memory_ready,
  output logic              rom_mapped,
  output logic [ADDR_W-1:0] first_instruction,
  output logic              entry_valid,
  output logic [FIDX_W:0]   func_count,
  output logic              error,
  output logic [2:0]        err_code,
  input  logic [FIDX_W-1:0] tbl_idx,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [LOCALS_W-1:0] tbl_locals
);

  typedef enum logic [3:0] {
    S_PTR, S_MAGIC, S_SEC_ID, S_SEC_LEN, S_SKIP, S_IMPORT, S_START,
    S_CODE_CNT, S_FN_LEN, S_FN_NLB, S_FN_LCNT, S_FN_LTYPE, S_FN_NEXT,
    S_DONE, S_ERROR
  } state_t;

  localparam logic [ADDR_W-1:0]   ONE_A = 1;
  localparam logic [FIDX_W:0]     ONE_F = 1;
  localparam logic [LOCALS_W-1:0] LMAX  = '1;

  state_t state_q, state_d;
  logic rd_q, rd_d, leb_done_q, leb_done_d;
  logic [ADDR_W-1:0] cur_q, cur_d, sec_end_q, sec_end_d;
  logic [ADDR_W-1:0] body_end_q, body_end_d, body_addr_q, body_addr_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic [31:0] acc_q, acc_d, nlb_q, nlb_d, sidx_q, sidx_d;
  logic [2:0] n_q, n_d, code_q, code_d, ecode;
  logic [7:0] sec_id_q, sec_id_d;
  logic [FIDX_W:0] nfn_q, nfn_d, fi_q, fi_d;
  logic [LOCALS_W-1:0] loc_q, loc_d;
  logic seen_q, seen_d, rom_q, rom_d, ev_q, ev_d, err_q, err_d;
  logic consume, is_leb, need, err_now, tbl_we;
  logic [4:0] sh;
  logic [32:0] sum;
  logic [ADDR_W-1:0] tbl_a_q [MAX_FUNCS];
  logic [LOCALS_W-1:0] tbl_l_q [MAX_FUNCS];

  function automatic logic [7:0] magic_byte(input logic [2:0] i);
    case (i)
      3'd1: return 8'h61;
      3'd2: return 8'h73;
      3'd3: return 8'h6D;
      3'd4: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_d = state_q; rd_d = rd_q; leb_done_d = leb_done_q;
    cur_d = cur_q; sec_end_d = sec_end_q; body_end_d = body_end_q;
    body_addr_d = body_addr_q; first_d = first_q;
    acc_d = acc_q; nlb_d = nlb_q; sidx_d = sidx_q;
    n_d = n_q; code_d = code_q; sec_id_d = sec_id_q;
    nfn_d = nfn_q; fi_d = fi_q; loc_d = loc_q;
    seen_d = seen_q; rom_d = rom_q; ev_d = ev_q; err_d = err_q;
    ecode = 3'd0; err_now = 1'b0; tbl_we = 1'b0;
    is_leb = 1'b0; need = 1'b0;
    sh = {2'b00, n_q} * 5'd7;
    sum = {1'b0, acc_q} + 33'(loc_q);
    consume = rd_q & memory_ready;
    unique case (state_q)
      S_PTR, S_MAGIC, S_SEC_ID, S_FN_LTYPE: need = 1'b1;
      S_SEC_LEN, S_IMPORT, S_START, S_CODE_CNT,
      S_FN_LEN, S_FN_NLB, S_FN_LCNT: begin
        is_leb = 1'b1;
        need = !leb_done_q;
      end
      default: ;
    endcase
    if (consume) cur_d = cur_q + ONE_A;
    if (consume && is_leb) begin
      acc_d = acc_q | (32'(data_out[6:0]) << sh);
      n_d = n_q + 3'd1;
      if (!data_out[7]) leb_done_d = 1'b1;
      else if (n_q == 3'd4) begin
        err_now = 1'b1; ecode = 3'd2;
      end
    end
    if (is_leb && leb_done_q) begin
      leb_done_d = 1'b0; acc_d = '0; n_d = '0;
    end
    unique case (state_q)
      S_PTR: if (consume) begin
        acc_d = acc_q | (32'(data_out) << {n_q, 3'b000});
        n_d = n_q + 3'd1;
        if (n_q == 3'(PTR_BYTES - 1)) begin
          cur_d = ADDR_W'(acc_d);
          acc_d = '0; n_d = '0; state_d = S_MAGIC;
        end
      end
      S_MAGIC: if (consume) begin
        n_d = n_q + 3'd1;
        if (data_out != magic_byte(n_q)) begin
          err_now = 1'b1; ecode = 3'd1;
        end else if (n_q == 3'd7) begin
          n_d = '0; state_d = S_SEC_ID;
        end
      end
      S_SEC_ID: if (consume) begin
        if (data_out != 8'h00) begin
          sec_id_d = data_out; state_d = S_SEC_LEN;
        end else if (seen_q && sidx_q >= 32'(fi_q)) begin
          err_now = 1'b1; ecode = 3'd4;
        end else begin
          state_d = S_DONE; rom_d = 1'b1; ev_d = seen_q;
          first_d = seen_q ? tbl_a_q[sidx_q[FIDX_W-1:0]] : '0;
        end
      end
      S_SEC_LEN: if (leb_done_q) begin
        sec_end_d = cur_q + ADDR_W'(acc_q);
        unique case (sec_id_q)
          8'd2: state_d = S_IMPORT;
          8'd8: state_d = S_START;
          8'd10: state_d = S_CODE_CNT;
          default: state_d = S_SKIP;
        endcase
      end
      S_SKIP: begin
        cur_d = sec_end_q; state_d = S_SEC_ID;
      end
      S_IMPORT: if (leb_done_q) begin
        if (acc_q != '0) begin
          err_now = 1'b1; ecode = 3'd6;
        end else begin
          cur_d = sec_end_q; state_d = S_SEC_ID;
        end
      end
      S_START: if (leb_done_q) begin
        sidx_d = acc_q; seen_d = 1'b1;
        cur_d = sec_end_q; state_d = S_SEC_ID;
      end
      S_CODE_CNT: if (leb_done_q) begin
        nfn_d = (FIDX_W+1)'(acc_q); fi_d = '0;
        if (acc_q > 32'(MAX_FUNCS)) begin
          err_now = 1'b1; ecode = 3'd3;
        end else if (acc_q != '0) state_d = S_FN_LEN;
        else if (cur_q != sec_end_q) begin
          err_now = 1'b1; ecode = 3'd5;
        end else state_d = S_SEC_ID;
      end
      S_FN_LEN: if (leb_done_q) begin
        body_end_d = cur_q + ADDR_W'(acc_q); state_d = S_FN_NLB;
      end
      S_FN_NLB: if (leb_done_q) begin
        nlb_d = acc_q; loc_d = '0; body_addr_d = cur_q;
        state_d = (acc_q == '0) ? S_FN_NEXT : S_FN_LCNT;
      end
      S_FN_LCNT: if (leb_done_q) begin
        loc_d = (sum > 33'(LMAX)) ? LMAX : LOCALS_W'(sum);
        state_d = S_FN_LTYPE;
      end
      S_FN_LTYPE: if (consume) begin
        nlb_d = nlb_q - 32'd1;
        if (nlb_q == 32'd1) begin
          body_addr_d = cur_q + ONE_A; state_d = S_FN_NEXT;
        end else state_d = S_FN_LCNT;
      end
      S_FN_NEXT: begin
        tbl_we = 1'b1; cur_d = body_end_q; fi_d = fi_q + ONE_F;
        if (fi_q + ONE_F != nfn_q) state_d = S_FN_LEN;
        else if (body_end_q != sec_end_q) begin
          err_now = 1'b1; ecode = 3'd5;
        end else state_d = S_SEC_ID;
      end
      default: ;
    endcase
    rd_d = rd_q ? !memory_ready : need;
    if (err_now) begin
      state_d = S_ERROR; err_d = 1'b1; code_d = ecode; rd_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_PTR; rd_q <= 1'b0; leb_done_q <= 1'b0;
      cur_q <= CODE_BASE; sec_end_q <= '0; body_end_q <= '0;
      body_addr_q <= '0; first_q <= '0;
      acc_q <= '0; nlb_q <= '0; sidx_q <= '0;
      n_q <= '0; code_q <= '0; sec_id_q <= '0;
      nfn_q <= '0; fi_q <= '0; loc_q <= '0;
      seen_q <= 1'b0; rom_q <= 1'b0; ev_q <= 1'b0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; rd_q <= rd_d; leb_done_q <= leb_done_d;
      cur_q <= cur_d; sec_end_q <= sec_end_d; body_end_q <= body_end_d;
      body_addr_q <= body_addr_d; first_q <= first_d;
      acc_q <= acc_d; nlb_q <= nlb_d; sidx_q <= sidx_d;
      n_q <= n_d; code_q <= code_d; sec_id_q <= sec_id_d;
      nfn_q <= nfn_d; fi_q <= fi_d; loc_q <= loc_d;
      seen_q <= seen_d; rom_q <= rom_d; ev_q <= ev_d; err_q <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_FUNCS; i++) begin
        tbl_a_q[i] <= '0;
        tbl_l_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_a_q[fi_q[FIDX_W-1:0]] <= body_addr_q;
      tbl_l_q[fi_q[FIDX_W-1:0]] <= loc_q;
    end
  end

  // Entries past the recorded count read as zero
  assign tbl_addr = ({1'b0, tbl_idx} < fi_q) ? tbl_a_q[tbl_idx] : '0;
  assign tbl_locals = ({1'b0, tbl_idx} < fi_q) ? tbl_l_q[tbl_idx] : '0;
  assign addr = rd_q ? cur_q : '0;
  assign memory_read_en = rd_q;
  assign rom_mapped = rom_q;
  assign first_instruction = first_q;
  assign entry_valid = ev_q;
  assign func_count = fi_q;
  assign error = err_q;
  assign err_code = code_q;

endmodule
